// File: rtl/vec3_normalize.sv
// Fixed-point vec3 normaliser: out = v/|v| truncated toward zero, out_len = floor(|v|), Q(DW-FRACT).FRACT.
// Latency: 2 + (DW+1) + 3*(DW+FRACT) cycles counted from the handshake cycle (179 at defaults), 2 for (0,0,0).
// Backpressure: one vector in flight; in_ready only in IDLE, results held while out_valid && !out_ready.
module vec3_normalize #(
    parameter int DATA_WIDTH = 32,
    parameter int FRACT      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    input  logic [DATA_WIDTH-1:0] in_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [DATA_WIDTH-1:0] out_z,
    output logic [DATA_WIDTH:0]   out_len,
    output logic                  zero_len
);
    localparam int DW  = DATA_WIDTH;
    localparam int SW  = 2*DW + 2;
    localparam int LW  = DW + 1;
    localparam int RW  = LW + 1;
    localparam int DVW = DW + FRACT;
    localparam int CW  = $clog2(DVW);
    localparam logic [CW-1:0] SQRT_LAST = CW'(LW - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DVW - 1);

    typedef enum logic [2:0] {IDLE, SQ, SQRT, DIV_X, DIV_Y, DIV_Z, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]     sgn;
    logic [DW-1:0]  mag_x, mag_y, mag_z;
    logic [SW-1:0]  s_reg;
    logic [RW-1:0]  srem;
    logic [LW-2:0]  root;
    logic [LW-1:0]  len;
    logic [LW-1:0]  drem;
    logic [DVW-1:0] dvd;
    logic [DW-2:0]  quot;
    logic [DW-1:0]  res_x, res_y;
    logic [CW-1:0]  cnt;

    logic [SW-1:0]  sq_sum;
    logic [RW+1:0]  sq_sh, sq_trial;
    logic           sq_ge;
    logic [LW-1:0]  root_nx;
    logic [LW:0]    dv_sh;
    logic           dv_ge;
    logic [DW-1:0]  qmag, qsigned, next_mag;
    logic           csgn;

    // Remainders stay narrow: the sqrt remainder never exceeds 2*root, the divide remainder stays below len.
    always_comb begin
        sq_sum   = SW'(mag_x) * SW'(mag_x) + SW'(mag_y) * SW'(mag_y) + SW'(mag_z) * SW'(mag_z);
        sq_sh    = {srem, s_reg[SW-1 -: 2]};
        sq_trial = (RW+2)'({root, 2'b01});
        sq_ge    = sq_sh >= sq_trial;
        root_nx  = {root, sq_ge};
        dv_sh    = {drem, dvd[DVW-1]};
        dv_ge    = dv_sh >= {1'b0, len};
        qmag     = {quot, dv_ge};
        csgn     = sgn[0];
        if (state == DIV_Y) csgn = sgn[1];
        if (state == DIV_Z) csgn = sgn[2];
        qsigned  = csgn ? -qmag : qmag;
        next_mag = (state == DIV_X) ? mag_y : mag_z;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SQ;
            SQ:      state_nx = (sq_sum == '0) ? DONE : SQRT;
            SQRT:    if (cnt == SQRT_LAST) state_nx = DIV_X;
            DIV_X:   if (cnt == DIV_LAST) state_nx = DIV_Y;
            DIV_Y:   if (cnt == DIV_LAST) state_nx = DIV_Z;
            DIV_Z:   if (cnt == DIV_LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn <= '0; mag_x <= '0; mag_y <= '0; mag_z <= '0;
            s_reg <= '0; srem <= '0; root <= '0; len <= '0;
            drem <= '0; dvd <= '0; quot <= '0; cnt <= '0;
            res_x <= '0; res_y <= '0;
            out_x <= '0; out_y <= '0; out_z <= '0; out_len <= '0; zero_len <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sgn      <= {in_z[DW-1], in_y[DW-1], in_x[DW-1]};
                    mag_x    <= in_x[DW-1] ? -in_x : in_x;
                    mag_y    <= in_y[DW-1] ? -in_y : in_y;
                    mag_z    <= in_z[DW-1] ? -in_z : in_z;
                    zero_len <= 1'b0;
                end
                SQ: begin
                    s_reg <= sq_sum;
                    srem  <= '0;
                    root  <= '0;
                    cnt   <= '0;
                    if (sq_sum == '0) begin
                        out_x <= '0; out_y <= '0; out_z <= '0; out_len <= '0;
                        zero_len <= 1'b1;
                    end
                end
                SQRT: begin
                    s_reg <= {s_reg[SW-3:0], 2'b00};
                    srem  <= sq_ge ? RW'(sq_sh - sq_trial) : RW'(sq_sh);
                    root  <= root_nx[LW-2:0];
                    cnt   <= cnt + CW'(1);
                    if (cnt == SQRT_LAST) begin
                        len  <= root_nx;
                        cnt  <= '0;
                        drem <= '0;
                        quot <= '0;
                        dvd  <= {mag_x, {FRACT{1'b0}}};
                    end
                end
                DIV_X, DIV_Y, DIV_Z: begin
                    dvd  <= {dvd[DVW-2:0], 1'b0};
                    drem <= dv_ge ? LW'(dv_sh - {1'b0, len}) : LW'(dv_sh);
                    quot <= qmag[DW-2:0];
                    cnt  <= cnt + CW'(1);
                    if (cnt == DIV_LAST) begin
                        cnt  <= '0;
                        drem <= '0;
                        quot <= '0;
                        dvd  <= {next_mag, {FRACT{1'b0}}};
                        if (state == DIV_X)      res_x <= qsigned;
                        else if (state == DIV_Y) res_y <= qsigned;
                        else begin
                            out_x   <= res_x;
                            out_y   <= res_y;
                            out_z   <= qsigned;
                            out_len <= len;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
